// File: rtl/sync_fifo_param_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the data-path and status signals of sync_fifo_param so producer,
// consumer and checkers can bind to a single handle. Clock and reset are kept
// as plain ports on the FIFO itself.
//
// Parameters
//   FIFO_WIDTH  data width in bits
//   CNT_W       width of usedw, must equal ceil(log2(FIFO_DEPTH+1)) of the FIFO
//
// Signals
//   wren, wrdata        write request and data          (master -> slave)
//   rden                read request                    (master -> slave)
//   err_clr             clears sticky overflow/underflow (master -> slave)
//   rddata              read data                       (slave -> master)
//   full, empty         occupancy extremes              (slave -> master)
//   almost_full/empty   threshold flags                 (slave -> master)
//   usedw               number of stored words          (slave -> master)
//   overflow/underflow  sticky rejected-request flags   (slave -> master)
//
// Request/acknowledge semantics: wren is a request that the FIFO accepts on a
// rising clk edge only when full is low at that edge; rden likewise is accepted
// only when empty is low. A request made against the opposite flag is dropped
// (not stalled) and recorded in the sticky overflow/underflow flag, so the
// master must look at full/empty before asserting a request it cares about.
// ----------------------------------------------------------------------------
interface sync_fifo_param_if #(
   parameter int FIFO_WIDTH = 140,
   parameter int CNT_W      = 4
);
   logic                  wren;
   logic [FIFO_WIDTH-1:0] wrdata;
   logic                  rden;
   logic                  err_clr;
   logic [FIFO_WIDTH-1:0] rddata;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      usedw;
   logic                  overflow;
   logic                  underflow;

   // Producer/consumer side.
   modport master (
      output wren, wrdata, rden, err_clr,
      input  rddata, full, empty, almost_full, almost_empty, usedw,
             overflow, underflow
   );

   // FIFO side.
   modport slave (
      input  wren, wrdata, rden, err_clr,
      output rddata, full, empty, almost_full, almost_empty, usedw,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with arbitrary (not necessarily power-of-two) depth,
// registered status flags, threshold flags and sticky error flags.
//
// Build option
//   SYNC_FIFO_FWFT_EN  when defined, rddata is first-word-fall-through: the
//                      head word is shown combinationally whenever the FIFO is
//                      not empty (0 when empty) and rden acknowledges it.
//                      When undefined, rddata is registered: it loads the head
//                      word on the edge that accepts a read and holds
//                      otherwise (one cycle of read latency).
//
// Parameters
//   FIFO_WIDTH  data width (1..1024)
//   FIFO_DEPTH  number of entries (2..1024)
//   AFULL_TH    almost_full  when usedw >= AFULL_TH  (1..FIFO_DEPTH)
//   AEMPTY_TH   almost_empty when usedw <= AEMPTY_TH (0..FIFO_DEPTH-1)
//
// Ports
//   clk   sole clock, all state changes on its rising edge
//   rst   synchronous active-high reset, dominates every other input
//   fifo  sync_fifo_param_if.slave: wren/wrdata/rden/err_clr in,
//         rddata/full/empty/almost_full/almost_empty/usedw/overflow/underflow out
// ----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter  int FIFO_WIDTH = 140,
   parameter  int FIFO_DEPTH = 8,
   parameter  int AFULL_TH   = 6,
   parameter  int AEMPTY_TH  = 2,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
   localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   sync_fifo_param_if.slave      fifo
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_r;
   logic [ADDR_W-1:0]     rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic                  overflow_r;
   logic                  underflow_r;

   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [ADDR_W-1:0]     wr_ptr_nxt;
   logic [ADDR_W-1:0]     rd_ptr_nxt;

   // ------------------------------------------------------------------------
   // Status decode. Everything is derived from the registered count, so an
   // accepted operation shows up in the flags in the cycle after its edge.
   // ------------------------------------------------------------------------
   assign full  = (count_r == CNT_W'(FIFO_DEPTH));
   assign empty = (count_r == '0);

   // full/empty are pre-edge values: a simultaneous write+read on a full FIFO
   // performs only the read, and on an empty FIFO only the write.
   assign wr_acc = fifo.wren & ~full;
   assign rd_acc = fifo.rden & ~empty;

   // Explicit wrap at FIFO_DEPTH-1 so non-power-of-two depths never index
   // past the last entry.
   always_comb begin
      wr_ptr_nxt = wr_ptr_r + ADDR_W'(1);
      if (wr_ptr_r == ADDR_W'(FIFO_DEPTH - 1)) begin
         wr_ptr_nxt = '0;
      end
      rd_ptr_nxt = rd_ptr_r + ADDR_W'(1);
      if (rd_ptr_r == ADDR_W'(FIFO_DEPTH - 1)) begin
         rd_ptr_nxt = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_r <= wr_ptr_nxt;
         end
         if (rd_acc) begin
            rd_ptr_r <= rd_ptr_nxt;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage. Contents are deliberately not reset; the pointers alone define
   // what is valid. A write coinciding with reset is dropped so that reset
   // fully dominates the request inputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr_r] <= fifo.wrdata;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky error flags. A new error in the same cycle as err_clr wins, so an
   // error is never lost to a clear that was aimed at an earlier one.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (fifo.wren && full) begin
            overflow_r <= 1'b1;
         end else if (fifo.err_clr) begin
            overflow_r <= 1'b0;
         end
         if (fifo.rden && empty) begin
            underflow_r <= 1'b1;
         end else if (fifo.err_clr) begin
            underflow_r <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read data path
   // ------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
   // Head word is always visible while data is present; rden pops it. A word
   // written into an empty FIFO appears once count_r becomes non-zero, i.e.
   // the cycle after its write edge.
   assign fifo.rddata = empty ? '0 : mem[rd_ptr_r];
`else
   logic [FIFO_WIDTH-1:0] rddata_r;

   // Load on the accepting edge only; a rejected read leaves rddata as it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         rddata_r <= '0;
      end else if (rd_acc) begin
         rddata_r <= mem[rd_ptr_r];
      end
   end

   assign fifo.rddata = rddata_r;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (count_r >= CNT_W'(AFULL_TH));
   assign fifo.almost_empty = (count_r <= CNT_W'(AEMPTY_TH));
   assign fifo.usedw        = count_r;
   assign fifo.overflow     = overflow_r;
   assign fifo.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed bench for sync_fifo_param at FIFO_DEPTH=6, FIFO_WIDTH=8,
// AFULL_TH=5, AEMPTY_TH=1. Expected read data follows the registered read
// path by default and the first-word-fall-through path when
// SYNC_FIFO_FWFT_EN is defined; flags, counts and errors are the same in both.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int W      = 8;
   localparam int DEPTH  = 6;
   localparam int AF_TH  = 5;
   localparam int AE_TH  = 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT   = 1'b1;
`else
   localparam bit FWFT   = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sync_fifo_param_if #(.FIFO_WIDTH(W), .CNT_W(CNT_W)) fifo_bus ();

   sync_fifo_param #(
      .FIFO_WIDTH (W),
      .FIFO_DEPTH (DEPTH),
      .AFULL_TH   (AF_TH),
      .AEMPTY_TH  (AE_TH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .fifo (fifo_bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------------------------------------------------------------
   // Driver: apply one cycle of requests, let the edge happen, then sample
   // 1 ns after it with the requests already released.
   // ---------------------------------------------------------------------
   task automatic cyc(input logic wr, input logic [W-1:0] d,
                      input logic rd, input logic clr);
      fifo_bus.wren    = wr;
      fifo_bus.wrdata  = d;
      fifo_bus.rden    = rd;
      fifo_bus.err_clr = clr;
      @(posedge clk);
      #1;
      fifo_bus.wren    = 1'b0;
      fifo_bus.wrdata  = '0;
      fifo_bus.rden    = 1'b0;
      fifo_bus.err_clr = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input int used,
                            input logic ovf, input logic unf);
      chk({tag, ".usedw"},     32'(fifo_bus.usedw),       32'(used));
      chk({tag, ".full"},      32'(fifo_bus.full),        32'(used == DEPTH));
      chk({tag, ".empty"},     32'(fifo_bus.empty),       32'(used == 0));
      chk({tag, ".afull"},     32'(fifo_bus.almost_full), 32'(used >= AF_TH));
      chk({tag, ".aempty"},    32'(fifo_bus.almost_empty),32'(used <= AE_TH));
      chk({tag, ".overflow"},  32'(fifo_bus.overflow),    32'(ovf));
      chk({tag, ".underflow"}, 32'(fifo_bus.underflow),   32'(unf));
   endtask

   logic [W-1:0] d;
   logic [W-1:0] last_rd;

   initial begin
      fifo_bus.wren    = 1'b0;
      fifo_bus.wrdata  = '0;
      fifo_bus.rden    = 1'b0;
      fifo_bus.err_clr = 1'b0;

      // -- reset state --------------------------------------------------
      rst = 1'b1;
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      rst = 1'b0;
      chk_flags("reset", 0, 0, 0);
      chk("reset.rddata", 32'(fifo_bus.rddata), 32'h0);

      // -- fill 0x10..0x15 ----------------------------------------------
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 8'(8'h10 + i), 0, 0);
         chk_flags($sformatf("fill%0d", i), i + 1, 0, 0);
         // Registered path still holds the reset value; FWFT shows the head.
         chk($sformatf("fill%0d.rddata", i), 32'(fifo_bus.rddata),
             FWFT ? 32'h10 : 32'h0);
      end

      // -- drain, FIFO order --------------------------------------------
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk_flags($sformatf("drain%0d", i), DEPTH - 1 - i, 0, 0);
         chk($sformatf("drain%0d.rddata", i), 32'(fifo_bus.rddata),
             FWFT ? ((i == DEPTH - 1) ? 32'h0 : 32'(8'h11 + i))
                  : 32'(8'h10 + i));
      end

      // -- wrap-around: 20 write/read pairs, pointers cross 5->0 --------
      last_rd = 8'h15;
      for (int k = 0; k < 20; k++) begin
         d = 8'(8'h40 + k);
         cyc(1, d, 0, 0);
         chk($sformatf("wrap%0d.w.usedw", k), 32'(fifo_bus.usedw), 32'd1);
         chk($sformatf("wrap%0d.w.rddata", k), 32'(fifo_bus.rddata),
             FWFT ? 32'(d) : 32'(last_rd));
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("wrap%0d.r.usedw", k), 32'(fifo_bus.usedw), 32'd0);
         chk($sformatf("wrap%0d.r.rddata", k), 32'(fifo_bus.rddata),
             FWFT ? 32'h0 : 32'(d));
         last_rd = d;
      end
      chk_flags("wrap.end", 0, 0, 0);

      // -- full boundary and overflow -----------------------------------
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, 8'(8'h20 + i), 0, 0);
      end
      chk_flags("full", 6, 0, 0);
      cyc(1, 8'h99, 0, 0);                // rejected write
      chk_flags("ovf.set", 6, 1, 0);
      cyc(0, 8'h00, 0, 1);                // err_clr alone
      chk_flags("ovf.clr", 6, 0, 0);
      cyc(1, 8'h99, 1, 0);                // only the read happens
      chk_flags("full.wr_rd", 5, 1, 0);
      chk("full.wr_rd.rddata", 32'(fifo_bus.rddata), FWFT ? 32'h21 : 32'h20);
      for (int i = 0; i < DEPTH - 1; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk($sformatf("fdrain%0d.rddata", i), 32'(fifo_bus.rddata),
             FWFT ? ((i == DEPTH - 2) ? 32'h0 : 32'(8'h22 + i))
                  : 32'(8'h21 + i));
      end
      chk_flags("fdrain.end", 0, 1, 0);
      cyc(0, 8'h00, 0, 1);
      chk_flags("ovf.clr2", 0, 0, 0);

      // -- empty boundary and underflow ---------------------------------
      cyc(1, 8'h77, 1, 0);                // only the write happens
      chk_flags("empty.wr_rd", 1, 0, 1);
      chk("empty.wr_rd.rddata", 32'(fifo_bus.rddata), FWFT ? 32'h77 : 32'h25);
      cyc(0, 8'h00, 0, 1);
      chk_flags("unf.clr", 1, 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk_flags("empty.read77", 0, 0, 0);
      chk("empty.read77.rddata", 32'(fifo_bus.rddata), FWFT ? 32'h0 : 32'h77);
      cyc(0, 8'h00, 1, 1);                // set beats coincident clear
      chk_flags("unf.set_prio", 0, 0, 1);
      chk("unf.set_prio.rddata", 32'(fifo_bus.rddata), FWFT ? 32'h0 : 32'h77);

      // -- reset mid-operation (underflow still set going in) -----------
      for (int i = 0; i < 4; i++) begin
         cyc(1, 8'(8'h50 + i), 0, 0);
      end
      chk_flags("pre_rst", 4, 0, 1);
      rst = 1'b1;
      cyc(1, 8'hEE, 0, 0);
      rst = 1'b0;
      chk_flags("mid_rst", 0, 0, 0);
      chk("mid_rst.rddata", 32'(fifo_bus.rddata), 32'h0);
      cyc(0, 8'h00, 1, 0);
      chk_flags("post_rst.read", 0, 0, 1);

      // -- data after reset starts from a clean FIFO --------------------
      cyc(1, 8'h61, 0, 0);
      cyc(1, 8'h62, 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("post_rst.rd0", 32'(fifo_bus.rddata), FWFT ? 32'h62 : 32'h61);
      cyc(0, 8'h00, 1, 0);
      chk("post_rst.rd1", 32'(fifo_bus.rddata), FWFT ? 32'h0 : 32'h62);
      chk_flags("post_rst.end", 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
